// File: rtl/ov7670_emulator.sv
`default_nettype none
// ============================================================================
// Module  : ov7670_emulator
// Purpose : Replays a 176x144 RGB444 frame buffer as an OV7670-style
//           Vsync/Href/Data byte stream, two bytes per pixel.
// Revision: 1.0 - initial release
// ============================================================================
module ov7670_emulator #(
    parameter int H_ACTIVE    = 176,
    parameter int V_ACTIVE    = 144,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic        Pclock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [11:0] PixelData,
    output logic [14:0] PAddress,
    output logic        Vsync,
    output logic        Href,
    output logic [7:0]  Data,
    output logic        FrameDone
);

    localparam int c_LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int c_BW       = $clog2(c_LINE_LEN);
    localparam int c_LW       = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT);
    localparam int c_YW       = $clog2(V_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_BW-1:0]   r_byte_cnt, w_byte_nxt;
    logic [c_LW-1:0]   r_line_cnt, w_line_nxt, w_last_line;
    logic [c_YW-1:0]   r_row, w_row_wrap;
    logic [c_BW-2:0]   w_pix;
    logic [14:0]       r_paddr, w_paddr_nxt;
    logic [7:0]        r_data;
    logic [3:0]        r_nibble;
    logic              r_vsync, r_href, r_frame_done;
    logic              w_line_end, w_period_end, w_href_nxt, w_first_byte, w_row_end;
    logic              w_done_nxt;

    // Next-state and counter advance; the output registers below are loaded
    // from these next values so every output lines up with r_state.
    always_comb begin
        w_state_nxt  = r_state;
        w_byte_nxt   = r_byte_cnt;
        w_line_nxt   = r_line_cnt;
        w_last_line  = c_LW'(V_FRONT - 1);
        w_line_end   = (r_byte_cnt == c_BW'(c_LINE_LEN - 1));
        case (r_state)
            S_VSYNC:  w_last_line = c_LW'(VSYNC_LINES - 1);
            S_VBACK:  w_last_line = c_LW'(V_BACK - 1);
            S_ACTIVE: w_last_line = c_LW'(V_ACTIVE - 1);
            default:  w_last_line = c_LW'(V_FRONT - 1);
        endcase
        w_period_end = w_line_end && (r_line_cnt == w_last_line);

        if (r_state == S_IDLE) begin
            if (Enable) begin
                w_state_nxt = S_VSYNC;
            end
        end else begin
            if (w_line_end) begin
                w_byte_nxt = '0;
                w_line_nxt = r_line_cnt + 1'b1;
            end else begin
                w_byte_nxt = r_byte_cnt + 1'b1;
            end
            if (w_period_end) begin
                w_line_nxt = '0;
                case (r_state)
                    S_VSYNC:  w_state_nxt = S_VBACK;
                    S_VBACK:  w_state_nxt = S_ACTIVE;
                    S_ACTIVE: w_state_nxt = S_VFRONT;
                    default:  w_state_nxt = Enable ? S_VSYNC : S_IDLE;
                endcase
            end
        end
    end

    // Pixel fetch: address of the following pixel is issued as the current
    // pixel's first byte goes out, giving the RAM two cycles of setup.
    always_comb begin
        w_href_nxt   = (w_state_nxt == S_ACTIVE) && (w_byte_nxt < c_BW'(2 * H_ACTIVE));
        w_first_byte = w_href_nxt && !w_byte_nxt[0];
        w_pix        = w_byte_nxt[c_BW-1:1];
        w_row_end    = (w_pix == (c_BW-1)'(H_ACTIVE - 1));
        w_row_wrap   = (r_row == c_YW'(V_ACTIVE - 1)) ? '0 : r_row + 1'b1;
        w_paddr_nxt  = w_row_end ? 15'(w_row_wrap) * 15'(H_ACTIVE)
                                 : 15'(r_row) * 15'(H_ACTIVE) + 15'(w_pix) + 15'd1;
        w_done_nxt   = (w_state_nxt == S_VFRONT)
                       && (w_byte_nxt == c_BW'(c_LINE_LEN - 1))
                       && (w_line_nxt == c_LW'(V_FRONT - 1));
    end

    always_ff @(posedge Pclock) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_byte_cnt   <= '0;
            r_line_cnt   <= '0;
            r_row        <= '0;
            r_paddr      <= '0;
            r_data       <= '0;
            r_nibble     <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_nxt;
            r_line_cnt   <= w_line_nxt;
            r_vsync      <= (w_state_nxt == S_VSYNC);
            r_href       <= w_href_nxt;
            r_frame_done <= w_done_nxt;
            if (w_first_byte) begin
                r_data   <= PixelData[11:4];
                r_nibble <= PixelData[3:0];
                r_paddr  <= w_paddr_nxt;
                if (w_row_end) begin
                    r_row <= w_row_wrap;
                end
            end else if (w_href_nxt) begin
                r_data <= {r_nibble, 4'h0};
            end else begin
                r_data <= 8'h00;
            end
        end
    end

    assign PAddress  = r_paddr;
    assign Vsync     = r_vsync;
    assign Href      = r_href;
    assign Data      = r_data;
    assign FrameDone = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ov7670_emulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_ov7670_emulator
// Purpose : Directed self-checking bench for ov7670_emulator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ov7670_emulator;

    logic        Pclock = 1'b0;
    logic        Reset  = 1'b1;
    logic        Enable = 1'b0;
    logic [11:0] PixelData = '0;
    logic [14:0] PAddress;
    logic        Vsync, Href, FrameDone;
    logic [7:0]  Data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] first6 [6] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h20};

    ov7670_emulator dut (
        .Pclock    (Pclock),
        .Reset     (Reset),
        .Enable    (Enable),
        .PixelData (PixelData),
        .PAddress  (PAddress),
        .Vsync     (Vsync),
        .Href      (Href),
        .Data      (Data),
        .FrameDone (FrameDone)
    );

    always #5 Pclock = ~Pclock;

    // Synchronous frame buffer whose word equals the low 12 address bits.
    always @(posedge Pclock) PixelData <= PAddress[11:0];

    task automatic tick();
        @(posedge Pclock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int y, input int c);
        logic [11:0] w;
        if (c >= 352) return 8'h00;
        w = 12'((y * 176 + c / 2) & 32'hFFF);
        return (c % 2 == 0) ? w[11:4] : {w[3:0], 4'h0};
    endfunction

    int vs_len, gap, overlap, href_hi, href_lo, line_err;
    int fd_cnt, fd_at, vf_err, idle_err, t_rise, t_done;

    initial begin
        // Reset state
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("rst_vsync", Vsync, 0);
        check("rst_href", Href, 0);
        check("rst_data", Data, 0);
        check("rst_paddr", PAddress, 0);
        check("rst_framedone", FrameDone, 0);

        // Frame 1: sync timing
        Enable = 1'b1;
        tick();
        check("vsync_rise", Vsync, 1);
        t_rise = cyc;
        vs_len = 0; overlap = 0;
        while (Vsync === 1'b1 && vs_len < 5000) begin
            if (Href === 1'b1) overlap++;
            vs_len++;
            tick();
        end
        check("vsync_len", vs_len, 1104);
        check("vsync_href_overlap", overlap, 0);
        gap = 0;
        while (Href !== 1'b1 && gap < 5000) begin
            gap++;
            tick();
        end
        check("vback_gap", gap, 736);

        // Active lines, Enable dropped mid line 50
        for (int y = 0; y < 144; y++) begin
            href_hi = 0; href_lo = 0; line_err = 0;
            for (int c = 0; c < 368; c++) begin
                if (Href === 1'b1) href_hi++;
                if (Href === 1'b0) href_lo++;
                if (Href !== (c < 352)) line_err++;
                if (Data !== exp_byte(y, c)) line_err++;
                if (Vsync !== 1'b0 || FrameDone !== 1'b0) line_err++;
                if (y == 0 && c < 6) check($sformatf("l0_byte%0d", c), Data, first6[c]);
                if (y == 0 && c == 0)   check("paddr_r0_b0", PAddress, 1);
                if (y == 0 && c == 349) check("paddr_r0_b349", PAddress, 175);
                if (y == 0 && c == 350) check("paddr_r0_b350", PAddress, 176);
                if (y == 0 && c == 360) check("paddr_blank_r1", PAddress, 176);
                if (y == 143 && c == 349) check("paddr_r143_b349", PAddress, 25343);
                if (y == 143 && c == 350) check("paddr_r143_b350", PAddress, 0);
                if (y == 50 && c == 10) Enable = 1'b0;
                tick();
            end
            check($sformatf("line%0d_stream", y), line_err, 0);
            if (y == 0) begin
                check("href_hi_l0", href_hi, 352);
                check("href_lo_l0", href_lo, 16);
            end
        end

        // Front porch and end of frame
        fd_cnt = 0; fd_at = -1; vf_err = 0; t_done = 0;
        for (int f = 0; f < 736; f++) begin
            if (FrameDone === 1'b1) begin
                fd_cnt++;
                fd_at  = f;
                t_done = cyc;
            end
            if (Href !== 1'b0 || Vsync !== 1'b0 || Data !== 8'h00) vf_err++;
            tick();
        end
        check("framedone_count", fd_cnt, 1);
        check("framedone_pos", fd_at, 735);
        check("frame_len", t_done - t_rise, 55567);
        check("vfront_quiet", vf_err, 0);

        idle_err = 0;
        for (int i = 0; i < 20; i++) begin
            if (Vsync !== 1'b0 || Href !== 1'b0 || Data !== 8'h00 ||
                PAddress !== 15'd0 || FrameDone !== 1'b0) idle_err++;
            tick();
        end
        check("idle_after_disable", idle_err, 0);

        // Frame 2: reset at line 10 byte 101
        Enable = 1'b1;
        tick();
        check("vsync_rise2", Vsync, 1);
        repeat (5621) tick();
        check("l10_b101_href", Href, 1);
        check("l10_b101_data", Data, 8'h20);
        check("l10_b101_paddr", PAddress, 1811);
        Reset = 1'b1;
        tick();
        check("midrst_href", Href, 0);
        check("midrst_data", Data, 0);
        check("midrst_paddr", PAddress, 0);
        check("midrst_vsync", Vsync, 0);
        Reset  = 1'b0;
        Enable = 1'b0;
        repeat (3) tick();
        check("postrst_idle_vsync", Vsync, 0);
        check("postrst_idle_href", Href, 0);

        // Clean restart
        Enable = 1'b1;
        tick();
        check("vsync_rise3", Vsync, 1);
        vs_len = 0;
        while (Vsync === 1'b1 && vs_len < 5000) begin
            vs_len++;
            tick();
        end
        check("vsync_len3", vs_len, 1104);
        gap = 0;
        while (Href !== 1'b1 && gap < 5000) begin
            gap++;
            tick();
        end
        check("vback_gap3", gap, 736);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("restart_byte%0d", c), Data, first6[c]);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
